// File: rtl/multi_split_radio.sv
// multi_split_radio: steers one received sample stream into CHANNELS
// independent STAGES-deep delay lines (broadcast, round-robin or explicit
// select) and counts samples that could not be delivered.
module multi_split_radio #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int STAGES   = 3,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = 2
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [WIDTH-1:0]          Receive,
    input  logic                      Receive_Valid,
    input  logic [1:0]                Mode,
    input  logic [SEL_W-1:0]          Select,
    input  logic [CHANNELS-1:0]       Enable,
    input  logic                      Clear_Drops,
    output logic [CHANNELS*WIDTH-1:0] Received,
    output logic [CHANNELS-1:0]       Received_Valid,
    output logic                      Dropped,
    output logic [CNT_W-1:0]          Drop_Count
);

    localparam logic [1:0] MODE_BROADCAST   = 2'd0;
    localparam logic [1:0] MODE_ROUND_ROBIN = 2'd1;
    localparam logic [1:0] MODE_SELECT      = 2'd2;
    localparam logic [1:0] MODE_HOLD        = 2'd3;

    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Routing state
    logic [1:0]          mode_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_d;
    logic [PTR_W-1:0]    eff_ptr;
    logic                rr_entry;
    logic                rr_found;
    logic [PTR_W-1:0]    rr_target;
    logic [PTR_W-1:0]    rr_next;
    logic [CHANNELS-1:0] route_mask;
    logic                drop;

    // Drop accounting
    logic                dropped_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;

    // Delay lines: per channel, STAGES entries of {valid, data}
    logic [STAGES-1:0]   line_vld_q [CHANNELS];
    logic [WIDTH-1:0]    line_dat_q [CHANNELS][STAGES];

    // Entering round-robin from another mode restarts the scan at channel 0
    assign rr_entry = (Mode == MODE_ROUND_ROBIN) && (mode_q != MODE_ROUND_ROBIN);
    assign eff_ptr  = rr_entry ? '0 : ptr_q;

    // Cyclic scan for the first enabled channel starting at the pointer
    always_comb begin
        rr_found  = 1'b0;
        rr_target = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            int idx;
            idx = int'(eff_ptr) + i;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!rr_found && Enable[idx]) begin
                rr_found  = 1'b1;
                rr_target = PTR_W'(idx);
            end
        end
    end

    assign rr_next = (rr_target == PTR_W'(CHANNELS - 1)) ? '0 : rr_target + PTR_W'(1);

    // Routing decision for this cycle's sample and the next pointer value
    always_comb begin
        route_mask = '0;
        ptr_d      = ptr_q;
        unique case (Mode)
            MODE_BROADCAST: begin
                if (Receive_Valid) begin
                    route_mask = Enable;
                end
            end
            MODE_ROUND_ROBIN: begin
                // eff_ptr carries the forced restart even when nothing is routed
                ptr_d = eff_ptr;
                if (Receive_Valid && rr_found) begin
                    route_mask[rr_target] = 1'b1;
                    ptr_d                 = rr_next;
                end
            end
            MODE_SELECT: begin
                // Out-of-range Select matches no channel and therefore drops
                if (Receive_Valid) begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        if (Select == SEL_W'(k) && Enable[k]) begin
                            route_mask[k] = 1'b1;
                        end
                    end
                end
            end
            MODE_HOLD: begin
                route_mask = '0;
            end
        endcase
    end

    assign drop = Receive_Valid && (route_mask == '0);

    // Saturating drop counter; clear has priority over a coincident drop
    always_comb begin
        cnt_d = cnt_q;
        if (Clear_Drops) begin
            cnt_d = '0;
        end else if (drop && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Routing and drop state registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mode_q    <= MODE_BROADCAST;
            ptr_q     <= '0;
            dropped_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            mode_q    <= Mode;
            ptr_q     <= ptr_d;
            dropped_q <= drop;
            cnt_q     <= cnt_d;
        end
    end

    // Free-running delay lines; non-targeted stage 0 loads an empty slot
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                line_vld_q[k] <= '0;
                for (int s = 0; s < STAGES; s++) begin
                    line_dat_q[k][s] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                line_vld_q[k][0] <= route_mask[k];
                line_dat_q[k][0] <= route_mask[k] ? Receive : '0;
                for (int s = 1; s < STAGES; s++) begin
                    line_vld_q[k][s] <= line_vld_q[k][s-1];
                    line_dat_q[k][s] <= line_dat_q[k][s-1];
                end
            end
        end
    end

    // Delay-line tails drive the channel outputs
    always_comb begin
        Received       = '0;
        Received_Valid = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            Received[k*WIDTH +: WIDTH] = line_dat_q[k][STAGES-1];
            Received_Valid[k]          = line_vld_q[k][STAGES-1];
        end
    end

    assign Dropped    = dropped_q;
    assign Drop_Count = cnt_q;

endmodule

// File: tb/tb_multi_split_radio.sv
// Directed self-checking bench for multi_split_radio: a default instance
// (4 channels) and a narrow instance (3 channels, 2-bit drop counter).
module tb_multi_split_radio;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: defaults
    logic [7:0]  a_recv = '0;
    logic        a_rv   = 1'b0;
    logic [1:0]  a_mode = 2'd0;
    logic [1:0]  a_sel  = '0;
    logic [3:0]  a_en   = '0;
    logic        a_clr  = 1'b0;
    logic [31:0] a_out;
    logic [3:0]  a_ov;
    logic        a_drop;
    logic [15:0] a_cnt;

    // Instance B: CHANNELS=3, CNT_W=2
    logic [7:0]  b_recv = '0;
    logic        b_rv   = 1'b0;
    logic [1:0]  b_mode = 2'd0;
    logic [1:0]  b_sel  = '0;
    logic [2:0]  b_en   = '0;
    logic        b_clr  = 1'b0;
    logic [23:0] b_out;
    logic [2:0]  b_ov;
    logic        b_drop;
    logic [1:0]  b_cnt;

    multi_split_radio dut_a (
        .Clock          (clk),
        .Reset          (rst),
        .Receive        (a_recv),
        .Receive_Valid  (a_rv),
        .Mode           (a_mode),
        .Select         (a_sel),
        .Enable         (a_en),
        .Clear_Drops    (a_clr),
        .Received       (a_out),
        .Received_Valid (a_ov),
        .Dropped        (a_drop),
        .Drop_Count     (a_cnt)
    );

    multi_split_radio #(
        .WIDTH    (8),
        .CHANNELS (3),
        .STAGES   (3),
        .CNT_W    (2),
        .SEL_W    (2)
    ) dut_b (
        .Clock          (clk),
        .Reset          (rst),
        .Receive        (b_recv),
        .Receive_Valid  (b_rv),
        .Mode           (b_mode),
        .Select         (b_sel),
        .Enable         (b_en),
        .Clear_Drops    (b_clr),
        .Received       (b_out),
        .Received_Valid (b_ov),
        .Dropped        (b_drop),
        .Drop_Count     (b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin expectations for Enable=1101, samples 1..5
    logic [3:0]  rr_v [5] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
    logic [31:0] rr_d [5] = '{32'h0000_0001, 32'h0002_0000, 32'h0300_0000,
                              32'h0000_0004, 32'h0005_0000};
    logic [1:0]  sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        // Reset state
        #1;
        check("rst_valid", 64'(a_ov), 64'h0);
        check("rst_data", 64'(a_out), 64'h0);
        check("rst_dropped", 64'(a_drop), 64'h0);
        check("rst_count", 64'(a_cnt), 64'h0);
        #3 rst = 1'b0;

        // Broadcast, Enable=1011, single sample 0x5A
        a_mode = 2'd0; a_en = 4'b1011; a_recv = 8'h5A; a_rv = 1'b1;
        step();
        a_rv = 1'b0; a_recv = '0;
        step();
        check("bc_t2_valid", 64'(a_ov), 64'h0);
        step();
        check("bc_t3_valid", 64'(a_ov), 64'hB);
        check("bc_t3_data", 64'(a_out), 64'h5A00_5A5A);
        check("bc_dropped", 64'(a_drop), 64'h0);
        step();
        check("bc_t4_valid", 64'(a_ov), 64'h0);
        check("bc_count", 64'(a_cnt), 64'h0);

        // Round-robin skip, Enable=1101, samples 1..5 back to back
        a_mode = 2'd1; a_en = 4'b1101;
        for (int i = 0; i < 8; i++) begin
            a_rv   = (i < 5);
            a_recv = (i < 5) ? 8'(i + 1) : 8'h00;
            step();
            if (i >= 2 && i < 7) begin
                check("rr_valid", 64'(a_ov), 64'(rr_v[i-2]));
                check("rr_data", 64'(a_out), 64'(rr_d[i-2]));
            end else begin
                check("rr_idle_valid", 64'(a_ov), 64'h0);
            end
        end
        a_rv = 1'b0;

        // Mode re-entry: pointer 3 -> samples go 3,0,1 leaving pointer 2
        a_en = 4'b1111;
        a_rv = 1'b1; a_recv = 8'h11; step();
        a_recv = 8'h22; step();
        a_recv = 8'h33; step();
        check("re_first_valid", 64'(a_ov), 64'h8);
        check("re_first_data", 64'(a_out), 64'h1100_0000);
        a_mode = 2'd0; a_rv = 1'b0; a_recv = '0; step();
        check("re_second_data", 64'(a_out), 64'h0000_0022);
        a_mode = 2'd1; a_rv = 1'b1; a_recv = 8'h77; step();
        check("re_third_data", 64'(a_out), 64'h0000_3300);
        a_rv = 1'b0; a_recv = '0; step();
        check("re_gap_valid", 64'(a_ov), 64'h0);
        step();
        check("re_entry_valid", 64'(a_ov), 64'h1);
        check("re_entry_data", 64'(a_out), 64'h0000_0077);

        // Reset mid-stream after one HOLD drop
        a_mode = 2'd3; a_rv = 1'b1; a_recv = 8'h99; step();
        check("hold_dropped", 64'(a_drop), 64'h1);
        check("hold_count", 64'(a_cnt), 64'h1);
        a_mode = 2'd0; a_en = 4'b1111;
        a_recv = 8'hAA; step();
        a_recv = 8'hBB; step();
        a_recv = 8'hCC; step();
        check("pre_rst_valid", 64'(a_ov), 64'hF);
        check("pre_rst_data", 64'(a_out), 64'hAAAA_AAAA);
        a_rv = 1'b0; a_recv = '0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(a_ov), 64'h0);
        check("async_rst_data", 64'(a_out), 64'h0);
        check("async_rst_count", 64'(a_cnt), 64'h0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_valid", 64'(a_ov), 64'h0);
            check("post_rst_data", 64'(a_out), 64'h0);
        end

        // Select boundaries on the 3-channel instance
        b_mode = 2'd2; b_en = 3'b111; b_sel = 2'd3; b_rv = 1'b1; b_recv = 8'h10;
        step();
        check("sel_oor_dropped", 64'(b_drop), 64'h1);
        check("sel_oor_count", 64'(b_cnt), 64'h1);
        b_sel = 2'd1; b_en = 3'b101; step();
        check("sel_dis_dropped", 64'(b_drop), 64'h1);
        check("sel_dis_count", 64'(b_cnt), 64'h2);
        b_sel = 2'd2; b_recv = 8'h42; step();
        check("sel_ok_dropped", 64'(b_drop), 64'h0);
        check("sel_ok_count", 64'(b_cnt), 64'h2);
        b_rv = 1'b0; b_recv = '0; step(); step();
        check("sel_ok_valid", 64'(b_ov), 64'h4);
        check("sel_ok_data", 64'(b_out), 64'h42_0000);

        // Saturation and clear
        b_clr = 1'b1; step();
        check("clr_count", 64'(b_cnt), 64'h0);
        b_clr = 1'b0;
        b_mode = 2'd3; b_rv = 1'b1; b_recv = 8'h55;
        for (int i = 0; i < 5; i++) begin
            step();
            check("sat_count", 64'(b_cnt), 64'(sat_exp[i]));
            check("sat_dropped", 64'(b_drop), 64'h1);
        end
        b_clr = 1'b1; step();
        check("clr_drop_count", 64'(b_cnt), 64'h0);
        check("clr_drop_dropped", 64'(b_drop), 64'h1);
        b_clr = 1'b0; b_rv = 1'b0; step();
        check("idle_dropped", 64'(b_drop), 64'h0);
        check("idle_count", 64'(b_cnt), 64'h0);
        check("hold_no_output", 64'(b_ov), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_split_radio.md
Name: multi_split_radio

Overview:
Clocked, parametrised successor to the fixed two-branch differential splitter. Takes one received sample stream and steers it into CHANNELS independent delay lines of STAGES registers each. Routing is per mode: broadcast, round-robin or explicit select. Sits between the receive front end and the downstream radio/wire consumers; it also counts samples it could not deliver.

Parameters:
WIDTH, 8, bits per received sample
CHANNELS, 4, number of output branches (>=2)
STAGES, 3, delay-line depth per branch (>=1); equals latency in cycles
CNT_W, 16, width of the drop counter
SEL_W, 2, width of Select (>= clog2(CHANNELS))

Ports:
Clock  input  1  single clock, rising edge
Reset  input  1  asynchronous, active-high; clears all state
Receive  input  WIDTH  incoming sample
Receive_Valid  input  1  sample present this cycle
Mode  input  2  0=BROADCAST, 1=ROUND_ROBIN, 2=SELECT, 3=HOLD
Select  input  SEL_W  target channel in SELECT mode
Enable  input  CHANNELS  per-channel enable mask
Clear_Drops  input  1  synchronous clear of Drop_Count
Received  output  CHANNELS*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
Received_Valid  output  CHANNELS  per-channel valid at delay-line tail
Dropped  output  1  one-cycle pulse: accepted-cycle sample not delivered
Drop_Count  output  CNT_W  saturating count of dropped samples

Behaviour:
- Reset (async, any time): all delay-line data and valid bits = 0, round-robin pointer = 0, Dropped = 0, Drop_Count = 0. In-flight samples are discarded; there is no partial drain.
- Pipeline: each channel has a STAGES-deep shift register of {valid, data}. It advances every cycle with no stall. Sample injected at cycle t appears on Received/Received_Valid at cycle t+STAGES. Throughput is 1 sample/cycle.
- Stage 0 of channel k loads {1, Receive} when the routing decision targets k. Otherwise it loads {0, 0}. Data of invalid stages is forced 0.
- Routing, evaluated only when Receive_Valid=1, using Mode/Select/Enable sampled that same cycle:
  - BROADCAST: every channel with Enable[k]=1 receives. Enable==0 -> drop.
  - ROUND_ROBIN: target is the first enabled channel found scanning ptr, ptr+1, ... cyclically mod CHANNELS. Pointer then becomes (target+1) mod CHANNELS. Enable==0 -> drop, pointer unchanged.
  - SELECT: Select<CHANNELS and Enable[Select]=1 -> that channel receives. Out-of-range or disabled -> drop.
  - HOLD: sample always dropped. Lines keep shifting and drain normally.
- Receive_Valid=0: no injection, no drop, pointer unchanged, regardless of mode.
- Pointer is forced to 0 on the cycle Mode transitions into ROUND_ROBIN from any other mode. That cycle's routing uses ptr=0.
- Mode or Enable changes never alter samples already inside a delay line.
- Dropped: registered, high the cycle after a dropped sample.
- Drop_Count: increments on each drop and saturates at 2^CNT_W-1 (no wrap).
  - Clear_Drops=1 sets it to 0.
  - A drop in the same cycle as Clear_Drops results in 0; clear wins.

Test Plan:
- Reset mid-stream: with samples in flight, assert Reset for 1 cycle -> all Received_Valid=0, Received=0 and Drop_Count=0 immediately (async). No stale sample emerges afterwards.
- BROADCAST latency: defaults, Enable=4'b1011, single sample 0x5A at cycle t -> channels 0, 1, 3 show 0x5A valid exactly at t+3; channel 2 invalid; Dropped stays 0.
- ROUND_ROBIN skip: Enable=4'b1101, 5 back-to-back samples 1..5 -> channels receive 0, 2, 3, 0, 2. Each output is 3 cycles after its injection.
- SELECT boundaries: CHANNELS=3, SEL_W=2, Select=3 with one valid sample -> Dropped pulse, Drop_Count=1. Select=1 with Enable[1]=0 -> Drop_Count=2.
- Drop saturation and clear: CNT_W=2, HOLD mode, 5 valid samples -> Drop_Count goes 1, 2, 3, 3, 3. Clear_Drops coincident with a drop -> 0.
- Mode re-entry: ROUND_ROBIN leaving pointer=2, switch to BROADCAST for one cycle, then back to ROUND_ROBIN with all enabled -> next sample goes to channel 0.
